// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops words from the read side of a FIFO and streams
// each word out as FWIDTH/BWIDTH beats on a valid/ready link. The next word is
// popped on the same edge that the final beat of the current word is accepted,
// so back-to-back words produce a continuous beat stream.
module fifo_word_serializer #(
    parameter int FWIDTH    = 32,
    parameter int BWIDTH    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNTW      = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              Flush,
    input  logic [FWIDTH-1:0] F_Data,
    input  logic              F_EmptyN,
    output logic              FOutN,
    output logic [BWIDTH-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Last,
    output logic [CNTW-1:0]   Words_Out
);

    localparam int NB = FWIDTH / BWIDTH;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state;
    logic [FWIDTH-1:0]        word_q;
    logic [CW-1:0]            cnt;
    logic [NB-1:0][BWIDTH-1:0] beats;
    logic [CW-1:0]            beat_idx;
    logic                     acc;
    logic                     lastacc;
    logic                     pop;

    // View the held word as an array of beats; beat i lives at bits [i*BWIDTH +: BWIDTH].
    assign beats = word_q;

    assign Out_Valid = (state == SHIFT);
    assign acc       = Out_Valid & Out_Ready;
    assign lastacc   = acc & (cnt == CNT_LAST);

    // Pop when idle, or when the last beat is leaving this cycle (no bubble).
    // Rst and Flush both suppress the strobe; F_EmptyN guards against underflow.
    assign pop   = ~Rst & ~Flush & En & F_EmptyN & ((state == IDLE) | lastacc);
    assign FOutN = ~pop;

    // NB is a power of two, so NB-1-cnt is just the bitwise inverse of cnt.
    assign beat_idx = MSB_FIRST ? ~cnt : cnt;
    assign Out_Data = beats[beat_idx];
    assign Out_Last = Out_Valid & (cnt == CNT_LAST);

    // State, word holding register, beat counter and transferred-word counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            word_q    <= '0;
            cnt       <= '0;
            Words_Out <= '0;
        end else if (Flush) begin
            // Abort the word in flight; a beat accepted this cycle is not counted.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (pop) begin
                word_q <= F_Data;
                cnt    <= '0;
                state  <= SHIFT;
            end else if (lastacc) begin
                state <= IDLE;
            end else if (acc) begin
                cnt <= cnt + 1'b1;
            end
            if (lastacc) begin
                Words_Out <= Words_Out + CNTW'(1);
            end
        end
    end

endmodule
